// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
// Holds the default line count, the word offsets of the four registers
// (decoded from Addr[3:2]) and the bit positions of the STATUS fields.
package irq_ctrl_pkg;

    // Six hardware lines, mapped onto MIPS HWInt[7:2]; line 5 wins priority.
    localparam int NLINES = 6;

    // Register selected by Addr[3:2].
    typedef enum logic [1:0] {
        IC_MASK   = 2'd0,
        IC_MODE   = 2'd1,
        IC_PEND   = 2'd2,
        IC_STATUS = 2'd3
    } icReg_e;

    // STATUS layout: [2:0] winning index, [3] valid, [13:8] overflow flags.
    localparam int STAT_IDX_LSB   = 0;
    localparam int STAT_IDX_W     = 3;
    localparam int STAT_VALID_BIT = 3;
    localparam int STAT_OVF_LSB   = 8;

endpackage

// File: rtl/irq_ctrl_if.sv
// Register bus between the address bridge and the interrupt controller.
//   Addr : word address, only [3:2] matters to the controller
//   WE   : write strobe, already qualified by the bridge chip-select
//   Din  : write data
//   Dout : combinational read data of the selected register
// master = bridge side, slave = controller side.
interface irq_ctrl_if;

    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;

    modport master (output Addr, output WE, output Din, input Dout);
    modport slave  (input Addr, input WE, input Din, output Dout);

endinterface

// File: rtl/irq_sync.sv
// Two-flop input pipeline for the raw interrupt lines plus rising-edge detect.
//   clk     : system clock
//   reset   : asynchronous, active-low
//   irq_i   : raw request lines
//   level_o : first pipeline stage (s1), used by level-mode lines
//   rise_o  : s1 & ~s2, one-cycle pulse on a rising request
module irq_sync #(
    parameter int NLINES = irq_ctrl_pkg::NLINES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NLINES-1:0] irq_i,
    output logic [NLINES-1:0] level_o,
    output logic [NLINES-1:0] rise_o
);

    logic [NLINES-1:0] s1_q;
    logic [NLINES-1:0] s2_q;

    // Both stages clear on reset, so a line held high across reset release
    // is seen as a fresh rising edge one cycle after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= irq_i;
            s2_q <= s1_q;
        end
    end

    assign level_o = s1_q;
    assign rise_o  = s1_q & ~s2_q;

endmodule

// File: rtl/irq_ctrl.sv
// Memory-mapped interrupt controller with per-line mask, level/edge mode,
// pending latch, overflow flags and a fixed-priority STATUS index.
//   clk     : system clock
//   reset   : asynchronous, active-low
//   bus     : register bus (Addr/WE/Din/Dout), slave side
//   irq_in  : raw interrupt requests
//   hw_int  : PEND & MASK, to CP0 Cause.IP
//   int_req : OR of hw_int
module irq_ctrl #(
    parameter int NLINES = irq_ctrl_pkg::NLINES
) (
    input  logic              clk,
    input  logic              reset,
    irq_ctrl_if.slave         bus,
    input  logic [NLINES-1:0] irq_in,
    output logic [NLINES-1:0] hw_int,
    output logic              int_req
);

    import irq_ctrl_pkg::*;

    logic [NLINES-1:0] s1;
    logic [NLINES-1:0] rise;

    irq_sync #(.NLINES(NLINES)) u_sync (
        .clk     (clk),
        .reset   (reset),
        .irq_i   (irq_in),
        .level_o (s1),
        .rise_o  (rise)
    );

    icReg_e regSel;
    logic   wrMask;
    logic   wrMode;
    logic   wrPend;
    logic   wrStatus;

    assign regSel   = icReg_e'(bus.Addr[3:2]);
    assign wrMask   = bus.WE && (regSel == IC_MASK);
    assign wrMode   = bus.WE && (regSel == IC_MODE);
    assign wrPend   = bus.WE && (regSel == IC_PEND);
    assign wrStatus = bus.WE && (regSel == IC_STATUS);

    logic [NLINES-1:0] mask_q, mask_d;
    logic [NLINES-1:0] mode_q, mode_d;
    logic [NLINES-1:0] pend_q, pend_d;
    logic [NLINES-1:0] ovf_q,  ovf_d;
    logic [NLINES-1:0] clrPend;
    logic [NLINES-1:0] clrOvf;
    logic [NLINES-1:0] modeChg;
    logic [NLINES-1:0] ovfSet;

    // Next-state logic. W1C on PEND only reaches edge-mode lines; a new edge
    // beats a same-cycle clear, and a MODE write wipes PEND/OVF of every line
    // whose mode actually flips.
    always_comb begin
        clrPend = wrPend   ? (bus.Din[NLINES-1:0] & mode_q)     : '0;
        clrOvf  = wrStatus ? bus.Din[STAT_OVF_LSB +: NLINES]    : '0;
        modeChg = wrMode   ? (bus.Din[NLINES-1:0] ^ mode_q)     : '0;
        ovfSet  = rise & mode_q & pend_q & ~clrPend;

        mask_d  = wrMask ? bus.Din[NLINES-1:0] : mask_q;
        mode_d  = wrMode ? bus.Din[NLINES-1:0] : mode_q;
        pend_d  = ((mode_q & (rise | (pend_q & ~clrPend))) | (~mode_q & s1)) & ~modeChg;
        ovf_d   = (ovfSet | (ovf_q & ~clrOvf)) & ~modeChg;
    end

    // Register state; everything clears immediately when reset goes low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            mode_q <= '0;
            pend_q <= '0;
            ovf_q  <= '0;
        end else begin
            mask_q <= mask_d;
            mode_q <= mode_d;
            pend_q <= pend_d;
            ovf_q  <= ovf_d;
        end
    end

    assign hw_int  = pend_q & mask_q;
    assign int_req = |hw_int;

    logic [STAT_IDX_W-1:0] irqIdx;

    // Fixed-priority encode: ascending scan so the highest active line is
    // the last assignment; index stays 0 when nothing is active.
    always_comb begin
        irqIdx = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (hw_int[i]) begin
                irqIdx = STAT_IDX_W'(i);
            end
        end
    end

    logic [31:0] statusWord;

    // STATUS word assembly.
    always_comb begin
        statusWord                                  = '0;
        statusWord[STAT_OVF_LSB +: NLINES]          = ovf_q;
        statusWord[STAT_VALID_BIT]                  = int_req;
        statusWord[STAT_IDX_LSB +: STAT_IDX_W]      = irqIdx;
    end

    // Read mux from current register state, so a same-cycle write is not
    // visible until the following cycle.
    always_comb begin
        bus.Dout = '0;
        case (regSel)
            IC_MASK:   bus.Dout[NLINES-1:0] = mask_q;
            IC_MODE:   bus.Dout[NLINES-1:0] = mode_q;
            IC_PEND:   bus.Dout[NLINES-1:0] = pend_q;
            IC_STATUS: bus.Dout             = statusWord;
            default:   bus.Dout             = '0;
        endcase
    end

    logic unusedBits;
    assign unusedBits = ^{bus.Addr[31:4], bus.Din};

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 The block SHALL have parameter NLINES, default 6, meaning the number of hardware interrupt lines; it maps to MIPS HWInt[7:2], and line 5 has the highest priority.
REQ-002 The block SHALL have port clk, input, 1 bit: the single system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port Addr, input, [31:2]: word address from the bridge; only Addr[3:2] is decoded.
REQ-005 The block SHALL have port WE, input, 1 bit: write strobe, already qualified by the bridge chip-select.
REQ-006 The block SHALL have port Din, input, 32 bits: write data.
REQ-007 The block SHALL have port Dout, output, 32 bits: combinational read data of the register selected by Addr[3:2].
REQ-008 The block SHALL have port irq_in, input, NLINES bits: raw requests from the timer IRQ outputs and external sources.
REQ-009 The block SHALL have port hw_int, output, NLINES bits: pending-and-enabled vector to CP0 Cause.IP.
REQ-010 The block SHALL have port int_req, output, 1 bit: OR of hw_int.

Function
REQ-011 Register map (Addr[3:2]):
- 0 = MASK[5:0], RW.
- 1 = MODE[5:0], RW; 1 = rising-edge, 0 = level.
- 2 = PEND[5:0]; read returns PEND; write is write-1-to-clear on edge-mode bits only.
- 3 = STATUS: [2:0] index of the highest pending-and-masked line, [3] valid, [13:8] OVF; write is write-1-to-clear on bits [13:8].
- Unused bits read 0 and ignore writes.
REQ-012 irq_in SHALL pass through a two-stage register pipeline s1 <= irq_in, s2 <= s1; edge = s1 & ~s2.
REQ-013 A level-mode PEND bit SHALL load s1 every cycle, and W1C on it SHALL have no effect.
REQ-014 An edge-mode PEND bit SHALL set on edge, hold until cleared by W1C, and on a simultaneous edge and W1C the set SHALL win.
REQ-015 Latency: irq_in rising before edge k SHALL appear in PEND, and hw_int if masked-in, after edge k+1 (2 cycles); level deassertion SHALL propagate with the same latency.
REQ-016 An edge on an edge-mode line whose PEND bit is already 1 and not being cleared that cycle SHALL set OVF[i].
REQ-017 OVF[i] SHALL hold until W1C; on a simultaneous set and W1C the set SHALL win.
REQ-018 hw_int SHALL equal PEND & MASK combinationally from registers, and int_req SHALL equal |hw_int.
REQ-019 The STATUS index SHALL be a fixed-priority encode of hw_int, highest line number wins; valid = int_req, and the index SHALL be 0 when not valid.
REQ-020 A write to MODE SHALL clear PEND[i] and OVF[i] for every line whose mode bit changes in that write; unchanged lines SHALL be unaffected.
REQ-021 A MASK write SHALL take effect on hw_int the cycle after the write edge, and PEND SHALL be unaffected by MASK.
REQ-022 Reads SHALL have no side effects.
REQ-023 Dout SHALL reflect register state before the current cycle's write.

Reset
REQ-024 Asserting reset low SHALL immediately, without waiting for clk, clear s1, s2, MASK, MODE, PEND and OVF to 0, forcing hw_int = 0, int_req = 0 and STATUS = 0.
REQ-025 Reset mid-operation SHALL discard all pending and overflow state with no residual interrupt after release.
REQ-026 After reset release, the first edge detection SHALL occur no earlier than the second clk edge.
REQ-027 A line held high through reset release SHALL register as a rising edge in edge mode.

Structure
REQ-028 A shared package SHALL hold NLINES, the register offset constants (IC_MASK=0, IC_MODE=1, IC_PEND=2, IC_STATUS=3), and the STATUS field bit positions.
REQ-029 One sub-module irq_sync SHALL implement the s1/s2 pipeline and edge output, with the same asynchronous active-low reset.
REQ-030 The priority encoder SHALL remain inline in irq_ctrl.

Verification
REQ-031 Scenario: MODE=0x00, MASK=0x01, irq_in[0]=1 at cycle 0 -> hw_int=0x01 and int_req=1 by cycle 2; irq_in[0]=0 -> hw_int=0 two cycles later.
REQ-032 Scenario: MODE=0x3F, MASK=0x3F, 1-cycle pulse on irq_in[2] -> PEND=0x04 held; writing PEND=0x04 -> PEND=0 next cycle.
REQ-033 Scenario: edge mode, two pulses on irq_in[3] with no clear -> STATUS[11]=1; a pulse coincident with W1C of PEND[3] -> PEND[3]=1.
REQ-034 Scenario: PEND=0x24 with MASK=0x3F -> STATUS=0x0D; MASK=0x1F -> STATUS=0x0A; MASK=0x00 -> STATUS=0 and int_req=0.
REQ-035 Scenario: PEND[1]=1 in edge mode, then MODE written 0x3D -> PEND[1]=0 and OVF[1]=0, other bits unchanged.
REQ-036 Scenario: reset pulsed low between clk edges with PEND=0x3F -> all outputs 0 before the next clk edge.
